// File: rtl/y86_memctl.sv
// ---------------------------------------------------------------------------
// y86_memctl -- data-memory access controller for a Y86 core.
//
// The core hands over one 32-bit access with a byte address of any alignment.
// The controller checks that the access is legal, splits it into word-aligned
// memory cycles, and reports completion with a one-cycle done pulse.
//   - A read that straddles two words fetches both words and funnel-shifts
//     them into the result.
//   - A write that straddles two words is a read-modify-write: both words
//     are fetched, the new bytes are merged in, and both words are written
//     back.
//
// Memory model assumed: synchronous read. The word for the mem_addr_o driven
// in cycle N appears on mem_dataout_i in cycle N+1.
//
// Address map:
//   RAM : byte addresses 0x000..0x17F. Every byte of the access must fall
//         inside RAM; an access whose end address wraps past 32 bits is
//         rejected.
//   IO  : aligned words at 0x180, 0x184, 0x188 and 0x18C only.
//         0x180 is read-only.
//   Any other access finishes with err_o=1 and issues no memory cycles.
//
// Configuration macro:
//   Y86_MEMCTL_UNALIGNED_EN
//     Defined   : unaligned RAM accesses are supported (two-word reads and
//                 read-modify-write).
//     Undefined : any access with vaddr[1:0] != 0 is rejected, and the
//                 second-word states (RD_HI, WR_HI) are never entered.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_ni       asynchronous active-low reset
//   req_i          access request, sampled only while ready_o=1
//   wr_i           1=write, 0=read (sampled with req_i)
//   vaddr_i        byte address (sampled with req_i)
//   wdata_i        little-endian write word (sampled with req_i)
//   ready_o        high only while idle
//   done_o         one-cycle completion pulse
//   err_o          valid with done_o; 1=access rejected
//   rdata_o        registered read result, held until the next access
//   mem_addr_o     word-aligned memory address (0 when no cycle is active)
//   mem_datain_o   memory write data (0 when mem_we_o=0)
//   mem_we_o       memory write strobe, one cycle per word written
//   mem_dataout_i  memory read data, one cycle after mem_addr_o
// ---------------------------------------------------------------------------
module y86_memctl (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [31:0] vaddr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_datain_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_dataout_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_LO  = 3'd1;
  localparam logic [2:0] S_RD_HI  = 3'd2;
  localparam logic [2:0] S_RD_CAP = 3'd3;
  localparam logic [2:0] S_WR_LO  = 3'd4;
  localparam logic [2:0] S_WR_HI  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [32:0] RAM_LIMIT = 33'h0_0000_0180;

  // -------------------------------------------------------------------------
  // State and latched request
  // -------------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic        wr_q,    wr_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q,   err_d;
  logic [31:0] lo_q,    lo_d;     // first word of a straddling access
  logic [31:0] hi_q,    hi_d;     // second word of a straddling access
  logic [31:0] rdata_q, rdata_d;

  // -------------------------------------------------------------------------
  // Legality check. It looks at the raw inputs because the decision is taken
  // in the same cycle the request is accepted.
  // -------------------------------------------------------------------------
  logic [32:0] end_addr;
  logic        ram_ok;
  logic        io_ok;
  logic        legal;

  // The adder is 33 bits wide. A carry out of bit 31 makes the sum at least
  // 2^32, so the single range compare also rejects wrapped accesses.
  assign end_addr = {1'b0, vaddr_i} + 33'd3;
  assign ram_ok   = (end_addr < RAM_LIMIT);
  assign io_ok    = (vaddr_i[31:4] == 28'h000_0018) && (vaddr_i[1:0] == 2'b00) &&
                    !(wr_i && (vaddr_i[3:2] == 2'b00));

`ifdef Y86_MEMCTL_UNALIGNED_EN
  assign legal = ram_ok || io_ok;
`else
  assign legal = (ram_ok || io_ok) && (vaddr_i[1:0] == 2'b00);
`endif

  // -------------------------------------------------------------------------
  // Datapath derived from the latched request
  // -------------------------------------------------------------------------
  logic [31:0] base;
  logic [1:0]  k;
  logic        unaligned;
  logic [4:0]  shamt;
  logic [63:0] rd_pair;
  logic [63:0] wr_mask;
  logic [63:0] merged;

  assign base  = {addr_q[31:2], 2'b00};
  assign k     = addr_q[1:0];
  assign shamt = {k, 3'b000};

`ifdef Y86_MEMCTL_UNALIGNED_EN
  assign unaligned = (k != 2'b00);
`else
  assign unaligned = 1'b0;
`endif

  // Read result: the two-word window shifted down by k bytes. The second
  // word is taken straight from the memory bus in RD_CAP.
  assign rd_pair = {mem_dataout_i, lo_q} >> shamt;

  // Write merge: the four bytes of wdata replace bytes k..k+3 of the
  // two-word window; every other byte keeps the value that was read.
  // When k=0 the low word is exactly wdata.
  assign wr_mask = 64'h0000_0000_FFFF_FFFF << shamt;
  assign merged  = ({hi_q, lo_q} & ~wr_mask) | ({32'h0, wdata_q} << shamt);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          wr_d    = wr_i;
          addr_d  = vaddr_i;
          wdata_d = wdata_i;
          err_d   = !legal;
          if (!legal)
            state_d = S_DONE;
          else if (wr_i && (vaddr_i[1:0] == 2'b00))
            state_d = S_WR_LO;
          else
            state_d = S_RD_LO;   // reads, and the read half of an unaligned write
        end
      end

      S_RD_LO: state_d = unaligned ? S_RD_HI : S_RD_CAP;

      S_RD_HI: begin
        lo_d    = mem_dataout_i;
        state_d = S_RD_CAP;
      end

      S_RD_CAP: begin
        if (unaligned) hi_d = mem_dataout_i;
        else           lo_d = mem_dataout_i;
        // A write passes through here only to fetch the old bytes, so the
        // previous read result stays on rdata_o.
        if (!wr_q) rdata_d = unaligned ? rd_pair[31:0] : mem_dataout_i;
        state_d = wr_q ? S_WR_LO : S_DONE;
      end

      S_WR_LO: state_d = unaligned ? S_WR_HI : S_DONE;

      S_WR_HI: state_d = S_DONE;

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. Reset aborts an access immediately. A write cut off
  // after its first word stays partly written.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      lo_q    <= 32'h0;
      hi_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. They decode the state register, so an asynchronous reset
  // returns them to idle values at once.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_addr_o   = 32'h0;
    mem_datain_o = 32'h0;
    mem_we_o     = 1'b0;
    case (state_q)
      S_RD_LO: mem_addr_o = base;
      S_RD_HI: mem_addr_o = base + 32'd4;
      S_WR_LO: begin
        mem_addr_o   = base;
        mem_datain_o = merged[31:0];
        mem_we_o     = 1'b1;
      end
      S_WR_HI: begin
        mem_addr_o   = base + 32'd4;
        mem_datain_o = merged[63:32];
        mem_we_o     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ready_o = (state_q == S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign err_o   = (state_q == S_DONE) && err_q;
  assign rdata_o = rdata_q;

endmodule
